// File: rtl/mem_bridge.sv
// mem_bridge: registered request/done bridge between the control unit and a
// synchronous memory array, with a programmable number of access cycles.
// Optional feature macro: MEM_BRIDGE_RDBUF_EN adds a one-entry read buffer
// that completes a repeated read of the same address without a memory access.
module mem_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cu_req,
    input  logic              cu_we,
    input  logic [ADDR_W-1:0] cu_addr,
    input  logic [DATA_W-1:0] cu_wdata,
    output logic              cu_busy,
    output logic              cu_done,
    output logic [DATA_W-1:0] cu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [7:0]        cnt_r;
    logic              start_s;
    logic              finish_s;
    logic              rd_hit_s;
    logic              cu_busy_r;
    logic              cu_done_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] cu_rdata_r;

`ifdef MEM_BRIDGE_RDBUF_EN
    logic              buf_valid_r;
    logic [ADDR_W-1:0] buf_tag_r;
    logic [DATA_W-1:0] buf_data_r;
    logic              hit_s;

    // A read of the buffered address can be answered without touching memory.
    assign rd_hit_s = buf_valid_r && !cu_we && (buf_tag_r == cu_addr);
    assign hit_s    = (state_r == ST_IDLE) && cu_req && rd_hit_s;
`else
    assign rd_hit_s = 1'b0;
`endif

    // Next-state logic and single-cycle start/finish strobes.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cu_req && rd_hit_s) begin
                    state_next_s = ST_DONE;
                end else if (cu_req) begin
                    state_next_s = ST_ACCESS;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = ST_DONE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status strobes registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cu_busy_r <= 1'b0;
            cu_done_r <= 1'b0;
            mem_en_r  <= 1'b0;
        end else begin
            cu_busy_r <= (state_next_s != ST_IDLE);
            cu_done_r <= (state_next_s == ST_DONE);
            mem_en_r  <= (state_next_s == ST_ACCESS);
        end
    end

    // Request capture, wait counter and write-enable lifetime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (start_s) begin
            cnt_r       <= CNT_LOAD;
            mem_we_r    <= cu_we;
            mem_addr_r  <= cu_addr;
            mem_wdata_r <= cu_wdata;
        end else if (finish_s) begin
            mem_we_r    <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            cnt_r       <= cnt_r - 8'd1;
        end
    end

    // Read result; writes never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cu_rdata_r <= '0;
        end else if (finish_s && !mem_we_r) begin
            cu_rdata_r <= mem_rdata;
`ifdef MEM_BRIDGE_RDBUF_EN
        end else if (hit_s) begin
            cu_rdata_r <= buf_data_r;
`endif
        end
    end

`ifdef MEM_BRIDGE_RDBUF_EN
    // Read buffer: filled by completed reads, kept coherent by write-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= '0;
            buf_data_r  <= '0;
        end else if (finish_s && !mem_we_r) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= mem_addr_r;
            buf_data_r  <= mem_rdata;
        end else if (finish_s && buf_valid_r && (buf_tag_r == mem_addr_r)) begin
            buf_data_r  <= mem_wdata_r;
        end
    end
`endif

    assign cu_busy   = cu_busy_r;
    assign cu_done   = cu_done_r;
    assign cu_rdata  = cu_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: randomized and directed bench for mem_bridge against a
// transaction-level reference (memory image, last read value, buffer tag).
module tb_mem_bridge;

    localparam int WC = 2;
`ifdef MEM_BRIDGE_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cu_req, cu_we;
    logic [7:0] cu_addr, cu_wdata;
    logic       cu_busy, cu_done, mem_en, mem_we;
    logic [7:0] cu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_init;
    logic [7:0] mem_arr [256];

    // Second and third instances: one and five access cycles.
    logic       req1, req5;
    logic       busy1, done1, en1, we1, busy5, done5, en5, we5;
    logic [7:0] rdata1, addr1, wdata1, rdata5, addr5, wdata5;
    logic [7:0] mrd1, mrd5;

    // Reference state.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata;
    bit         rb_valid;
    logic [7:0] rb_tag;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    mem_bridge #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst_n(rst_n), .cu_req(cu_req), .cu_we(cu_we),
        .cu_addr(cu_addr), .cu_wdata(cu_wdata), .cu_busy(cu_busy),
        .cu_done(cu_done), .cu_rdata(cu_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_bridge #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cu_req(req1), .cu_we(1'b0),
        .cu_addr(8'hFF), .cu_wdata(8'h00), .cu_busy(busy1),
        .cu_done(done1), .cu_rdata(rdata1), .mem_en(en1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_rdata(mrd1)
    );

    mem_bridge #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .cu_req(req5), .cu_we(1'b0),
        .cu_addr(8'hFF), .cu_wdata(8'h00), .cu_busy(busy5),
        .cu_done(done5), .cu_rdata(rdata5), .mem_en(en5),
        .mem_we(we5), .mem_addr(addr5), .mem_wdata(wdata5),
        .mem_rdata(mrd5)
    );

    assign mrd1      = addr1 ^ 8'hA5;
    assign mrd5      = addr5 ^ 8'hA5;
    assign mem_rdata = mem_arr[mem_addr];

    // Synchronous memory model for the main instance.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'((i * 37 + 11) & 255);
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One CU transfer; called and returning on a falling edge.
    task automatic xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input bit poke);
        bit hit;
        int exp_lat, en_cnt, we_cnt, done_at;
        hit     = RDBUF && !we && rb_valid && (rb_tag == addr);
        exp_lat = hit ? 1 : WC + 1;
        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            ref_rdata = ref_mem[addr];
            rb_valid  = 1'b1;
            rb_tag    = addr;
        end
        en_cnt = 0; we_cnt = 0; done_at = 0;
        cu_req = 1'b1; cu_we = we; cu_addr = addr; cu_wdata = wdata;
        @(posedge clk);
        #1;
        cu_req = 1'b0; cu_we = 1'($urandom); cu_addr = 8'($urandom); cu_wdata = 8'($urandom);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("busy_n1", cu_busy, 1);
            if (k == 1 && poke) begin cu_req = 1'b1; cu_we = 1'b0; cu_addr = 8'h20; end
            if (k == 2) cu_req = 1'b0;
            if (mem_en) begin
                en_cnt++;
                if (mem_addr !== addr) check_eq("mem_addr", mem_addr, addr);
                if (we && mem_wdata !== wdata) check_eq("mem_wdata", mem_wdata, wdata);
            end
            if (mem_we) we_cnt++;
            if (cu_done) begin done_at = k; break; end
        end
        cu_req = 1'b0;
        check_eq("done_latency", done_at, exp_lat);
        check_eq("mem_en_cycles", en_cnt, hit ? 0 : WC);
        check_eq("mem_we_cycles", we_cnt, we ? WC : 0);
        check_eq("cu_rdata", cu_rdata, ref_rdata);
        @(negedge clk);
        check_eq("done_one_cycle", cu_done, 0);
        check_eq("idle_after", {cu_busy, mem_en}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idle_en;
        int done_at;
        logic [7:0] a;
        logic       w;

        rst_n = 1'b0; mem_init = 1'b1;
        cu_req = 1'b0; cu_we = 1'b0; cu_addr = 8'h00; cu_wdata = 8'h00;
        req1 = 1'b0; req5 = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
        ref_rdata = 8'h00; rb_valid = 1'b0; rb_tag = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", cu_busy, 0);
        check_eq("rst_done", cu_done, 0);
        check_eq("rst_en", mem_en, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_rdata", cu_rdata, 0);
        mem_init = 1'b0; rst_n = 1'b1;
        idle_en = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_en || cu_busy) idle_en++;
        end
        check_eq("idle_no_en", idle_en, 0);

        // Write then read, repeated read, write-through then read.
        xfer(1'b1, 8'h10, 8'h3C, 1'b0);
        xfer(1'b0, 8'h10, 8'h00, 1'b0);
        check_eq("wr_rd_3c", cu_rdata, 8'h3C);
        xfer(1'b0, 8'h10, 8'h00, 1'b0);
        xfer(1'b1, 8'h10, 8'h55, 1'b0);
        xfer(1'b0, 8'h10, 8'h00, 1'b0);
        check_eq("wr_rd_55", cu_rdata, 8'h55);

        // Request pulsed during a write access is dropped.
        xfer(1'b1, 8'h30, 8'hA7, 1'b1);
        check_eq("poke_rdata", cu_rdata, 8'h55);
        idle_en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_en || cu_busy) idle_en++;
        end
        check_eq("poke_no_extra", idle_en, 0);

        // Reset in the first access cycle of a read.
        cu_req = 1'b1; cu_we = 1'b0; cu_addr = 8'h40;
        @(posedge clk);
        #1 cu_req = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_en_before", mem_en, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_en_async", mem_en, 0);
        check_eq("mid_rst_busy", cu_busy, 0);
        done_at = 0;
        repeat (2) begin
            @(negedge clk);
            if (cu_done) done_at++;
        end
        check_eq("mid_rst_no_done", done_at, 0);
        rst_n = 1'b1;
        ref_rdata = 8'h00; rb_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_idle", {cu_busy, mem_en, cu_rdata}, 0);
        xfer(1'b0, 8'h10, 8'h00, 1'b0);
        xfer(1'b0, 8'h40, 8'h00, 1'b0);

        // Randomized traffic concentrated on a few addresses.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: a = 8'h10;
                1: a = 8'h11;
                2: a = 8'h12;
                default: a = 8'($urandom);
            endcase
            w = 1'($urandom);
            xfer(w, a, 8'($urandom), w && ($urandom_range(0, 3) == 0));
        end

        // Latency with one and five access cycles.
        for (int s = 0; s < 2; s++) begin
            if (s == 0) req1 = 1'b1; else req5 = 1'b1;
            @(posedge clk);
            #1 req1 = 1'b0; req5 = 1'b0;
            done_at = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if ((s == 0) ? done1 : done5) begin done_at = k; break; end
            end
            check_eq(s == 0 ? "w1_latency" : "w5_latency", done_at, s == 0 ? 2 : 6);
            check_eq(s == 0 ? "w1_rdata" : "w5_rdata", s == 0 ? rdata1 : rdata5, 8'h5A);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Parametrised, handshaked interface between the control unit (CU) and the memory array. It replaces the single-cycle ctrl-driven address/instruction latch with a registered request/done protocol, configurable address/data widths and a programmable memory wait-state count. An optional one-entry read buffer returns a repeated read without a memory access. It sits between the CU (request side) and the synchronous memory (mem side).

## Interface
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.
- `WAIT_CYCLES`, default 2: memory access cycles per transfer; legal range 1..255.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cu_req`  in  1  CU request; sampled only in IDLE.
- `cu_we`  in  1  0 = read, 1 = write; sampled with `cu_req`.
- `cu_addr`  in  ADDR_W  transfer address.
- `cu_wdata`  in  DATA_W  write data.
- `cu_busy`  out  1  high whenever state is not IDLE.
- `cu_done`  out  1  one-cycle completion pulse.
- `cu_rdata`  out  DATA_W  last read result; held until the next read completes.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable; valid only while `mem_en` = 1.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  memory read data; must be valid in the last ACCESS cycle.

## Operation
- States: IDLE, ACCESS, DONE. Reset → IDLE.
- IDLE: if `cu_req` = 1 at the edge, register `cu_we`/`cu_addr`/`cu_wdata` into `mem_we`/`mem_addr`/`mem_wdata`, load the wait counter with WAIT_CYCLES−1, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: `mem_en` = 1. The counter decrements each cycle. At the edge where the counter = 0:
  - Read: `cu_rdata` ← `mem_rdata`.
  - Then go to DONE.
- DONE: `cu_done` = 1 for exactly one cycle, then IDLE.
- `cu_req` in ACCESS or DONE is ignored; it is not queued. The CU must re-assert it after `cu_busy` falls.
- A write never changes `cu_rdata`.
- Outside ACCESS, `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last values.
- Counter width is 8 bits, with no wrap inside a transfer.
- Reset values: `cu_busy`, `cu_done`, `mem_en` and `mem_we` are 0; `cu_rdata`, `mem_addr` and `mem_wdata` are 0; the counter is 0.
- Reset asserted mid-transfer: immediate return to IDLE, `mem_en` drops asynchronously, no `cu_done` pulse, and the transfer is lost.

## Timing
- `cu_req` is sampled at edge N.
- ACCESS occupies cycles N+1 .. N+WAIT_CYCLES.
- `cu_done` and valid `cu_rdata` appear in cycle N+WAIT_CYCLES+1.
- The block is in IDLE at cycle N+WAIT_CYCLES+2, and the earliest next request is sampled at that edge.
- Throughput: one transfer per WAIT_CYCLES+2 cycles.
- All outputs are registered. There is no combinational path from `cu_*` to `mem_*`.

## Configuration
- Macro `MEM_BRIDGE_RDBUF_EN`.
- Defined: one-entry read buffer holding valid, tag (ADDR_W) and data (DATA_W); valid is cleared by reset.
  - Read hit (valid and tag = `cu_addr` in IDLE): go IDLE→DONE directly and load `cu_rdata` from the buffer. `mem_en` stays 0. `cu_done` appears at N+1.
  - Read miss: normal ACCESS, then tag/data are filled at completion.
  - Write to the tagged address: buffer data is updated at write completion (write-through).
  - Write to another address: buffer unchanged.
  - Reset mid-miss: buffer stays invalid.
- Undefined: no buffer logic; every read performs a full ACCESS.

## Test plan
- Reset: hold `rst_n` = 0 → all outputs 0, `cu_busy` = 0. Release, idle 5 cycles → `mem_en` never asserted.
- Write then read, WAIT_CYCLES = 2: write 0x3C to 0x10, then read 0x10 with `mem_rdata` model returning 0x3C.
  - `mem_en` high for exactly 2 cycles per transfer, `mem_we` = 1 only on the write.
  - `cu_done` at N+3; `cu_rdata` = 0x3C.
- Request during busy: pulse `cu_req` (read 0x20) during ACCESS of a write → ignored, only one transfer, `cu_rdata` unchanged.
- Mid-transfer reset: assert `rst_n` = 0 in the first ACCESS cycle → `mem_en` drops that cycle, no `cu_done`, IDLE after release.
- WAIT_CYCLES = 1 and 5: read 0xFF → `cu_done` at N+2 and N+6 respectively.
- With `MEM_BRIDGE_RDBUF_EN`:
  - Read 0x10 twice → second read has `cu_done` at N+1 and `mem_en` stays 0.
  - Write 0x55 to 0x10, then read 0x10 → hit returns 0x55.
  - Without the macro, the same sequence → full access each time.
